lu_pipe: RTL and testbench

LU_PIPE -- requirements
Module: lu_pipe

---
 rtl/lu_pipe.sv | 100 ++++++++++
 tb/tb_lu_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_pipe.sv
// Two-stage bitwise logic unit with valid/ready handshakes, a result
// accumulator that can stand in for operand A, and a delivered-result counter.
module lu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             zero,
  output logic             par,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid;
  logic             s1_acc_en;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_sel;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;
  logic             s2_load;
  logic             in_xfer;
  logic             out_xfer;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !rst && (!s1_valid || s2_load);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // acc is read at S2-load time, so a chained acc op sees the result
  // that is being written into S2 on the same edge its predecessor leaves S1.
  always_comb begin
    op_a   = s1_acc_en ? acc : s1_a;
    result = '0;
    case (s1_sel)
      3'b000:  result = op_a ^ s1_b;
      3'b001:  result = ~(op_a ^ s1_b);
      3'b010:  result = op_a | s1_b;
      3'b011:  result = ~(op_a | s1_b);
      3'b100:  result = op_a & s1_b;
      3'b101:  result = ~(op_a & s1_b);
      3'b110:  result = ~op_a;
      default: result = s1_b;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_acc_en <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_sel    <= '0;
    end else begin
      if (in_xfer) begin
        s1_a      <= a;
        s1_b      <= b;
        s1_sel    <= sel;
        s1_acc_en <= acc_en;
      end
      if (in_xfer)      s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      zero      <= 1'b1;
      par       <= 1'b0;
      acc       <= '0;
    end else begin
      if (s2_load) begin
        s    <= result;
        zero <= (result == '0);
        par  <= ^result;
        acc  <= result;
      end
      if (s2_load)       out_valid <= 1'b1;
      else if (out_xfer) out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           op_count <= '0;
    else if (out_xfer) op_count <= op_count + 1'b1;
  end

endmodule

// File: tb/tb_lu_pipe.sv
// Directed bench for lu_pipe; a second instance with a 4-bit counter
// shares the stimulus to exercise counter wrap.
module tb_lu_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] sel = '0;
  logic       acc_en = 1'b0;
  logic       out_ready = 1'b0;

  logic        in_ready, out_valid, zero, par;
  logic [7:0]  s;
  logic [15:0] op_count;
  logic        in_ready4, out_valid4, zero4, par4;
  logic [7:0]  s4;
  logic [3:0]  op_count4;

  int checks = 0;
  int failures = 0;

  lu_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .acc_en(acc_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .zero(zero), .par(par), .op_count(op_count)
  );

  lu_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .sel(sel), .acc_en(acc_en),
    .out_valid(out_valid4), .out_ready(out_ready),
    .s(s4), .zero(zero4), .par(par4), .op_count(op_count4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [2:0] isel, input logic iacc);
    in_valid = v; a = ia; b = ib; sel = isel; acc_en = iacc;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++;
    if ({out_valid, s, zero, par} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got v=%b s=%h z=%b p=%b exp v=0 s=00 z=1 p=0", out_valid, s, zero, par);
    end
    checks++;
    if (op_count !== 16'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_ops_sweep();
    logic [7:0] exp_s [8];
    exp_s = '{8'h33, 8'hCC, 8'h3F, 8'hC0, 8'h0C, 8'hF3, 8'hF0, 8'h3C};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(1'b1, 8'h0F, 8'h3C, 3'(i), 1'b0);
      else       drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
      if (i < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL sweep_in_ready i=%0d got=%b exp=1", i, in_ready); end
      end
      tick();
      checks++;
      if (i == 0) begin
        if (out_valid !== 1'b0) begin failures++; $display("FAIL sweep_latency got out_valid=%b exp=0", out_valid); end
      end else if (out_valid !== 1'b1 || s !== exp_s[i-1]) begin
        failures++;
        $display("FAIL sweep_result sel=%0d got v=%b s=%h exp v=1 s=%h", i-1, out_valid, s, exp_s[i-1]);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || op_count !== 16'd8) begin
      failures++;
      $display("FAIL sweep_drain got v=%b cnt=%0d exp v=0 cnt=8", out_valid, op_count);
    end
  endtask

  task automatic test_flags();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 8'hAA, 8'hAA, 3'b000, 1'b0);
    tick();
    drive(1'b1, 8'h01, 8'h00, 3'b010, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    checks++;
    if ({out_valid, s, zero, par} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL flags_zero got v=%b s=%h z=%b p=%b exp v=1 s=00 z=1 p=0", out_valid, s, zero, par);
    end
    tick();
    checks++;
    if ({out_valid, s, zero, par} !== {1'b1, 8'h01, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL flags_par got v=%b s=%h z=%b p=%b exp v=1 s=01 z=0 p=1", out_valid, s, zero, par);
    end
  endtask

  task automatic test_acc_chain();
    logic [7:0] exp_s [3];
    exp_s = '{8'h55, 8'hAA, 8'h55};
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 8'h00, 8'h55, 3'b111, 1'b0);
    tick();
    drive(1'b1, 8'h00, 8'hFF, 3'b000, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b1 || s !== exp_s[0]) begin
      failures++; $display("FAIL acc_load got v=%b s=%h exp v=1 s=%h", out_valid, s, exp_s[0]);
    end
    tick();
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || s !== exp_s[1]) begin
      failures++; $display("FAIL acc_chain1 got v=%b s=%h exp v=1 s=%h", out_valid, s, exp_s[1]);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || s !== exp_s[2]) begin
      failures++; $display("FAIL acc_chain2 got v=%b s=%h exp v=1 s=%h", out_valid, s, exp_s[2]);
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 8'h0F, 8'h3C, 3'b000, 1'b0);
    tick();
    drive(1'b1, 8'h0F, 8'h3C, 3'b010, 1'b0);
    tick();
    drive(1'b1, 8'h0F, 8'h3C, 3'b100, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_full got in_ready=%b exp=0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || s !== 8'h33 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got v=%b s=%h rdy=%b exp v=1 s=33 rdy=0", i, out_valid, s, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release got in_ready=%b exp=1", in_ready); end
    tick();
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || s !== 8'h3F || op_count !== 16'd1) begin
      failures++; $display("FAIL stall_item2 got v=%b s=%h cnt=%0d exp v=1 s=3f cnt=1", out_valid, s, op_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || s !== 8'h0C || op_count !== 16'd2) begin
      failures++; $display("FAIL stall_item3 got v=%b s=%h cnt=%0d exp v=1 s=0c cnt=2", out_valid, s, op_count);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || op_count !== 16'd3) begin
      failures++; $display("FAIL stall_count got v=%b cnt=%0d exp v=0 cnt=3", out_valid, op_count);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 8'h00, 8'h77, 3'b111, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 8'h00, 8'h11, 3'b111, 1'b0);
    tick();
    drive(1'b1, 8'h00, 8'h22, 3'b111, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, s, zero, op_count} !== {1'b1 ^ 1'b1, 8'h00, 1'b1, 16'd0}) begin
      failures++;
      $display("FAIL midrst_clear got v=%b s=%h z=%b cnt=%0d exp v=0 s=00 z=1 cnt=0", out_valid, s, zero, op_count);
    end
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale cyc=%0d got out_valid=%b exp=0", i, out_valid); end
    end
    // acc must have been cleared: 0 ^ 0x12 = 0x12
    drive(1'b1, 8'hFF, 8'h12, 3'b000, 1'b1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || s !== 8'h12 || op_count !== 16'd0) begin
      failures++; $display("FAIL midrst_acc got v=%b s=%h cnt=%0d exp v=1 s=12 cnt=0", out_valid, s, op_count);
    end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(i), 8'h00, 3'b010, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || s !== 8'd15) begin
      failures++; $display("FAIL b2b_order got v=%b s=%h exp v=1 s=0f", out_valid, s);
    end
    tick();
    tick();
    checks++;
    if (op_count4 !== 4'd1) begin failures++; $display("FAIL wrap_cnt4 got=%0d exp=1", op_count4); end
    checks++;
    if (op_count !== 16'd17) begin failures++; $display("FAIL wrap_cnt16 got=%0d exp=17", op_count); end
  endtask

  initial begin
    test_reset();
    test_ops_sweep();
    test_flags();
    test_acc_chain();
    test_stall();
    test_reset_midflight();
    test_back_to_back_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
